// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - shared FSM state, mode and counter constants for lfsr_param
package lfsr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_LOCKED = 2'd2
    } lfsr_state_e;

    localparam int LFSR_FIB = 0;
    localparam int LFSR_GAL = 1;

    localparam int LFSR_CNT_W = 32;
    localparam logic [LFSR_CNT_W-1:0] LFSR_CNT_MAX = '1;

endpackage

// File: rtl/lfsr_step.sv
// rtl/lfsr_step.sv - one combinational LFSR step, Fibonacci or Galois form
module lfsr_step
    import lfsr_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int MODE  = LFSR_FIB
) (
    input  logic [WIDTH-1:0] state_i,
    input  logic [WIDTH-1:0] poly_i,
    output logic [WIDTH-1:0] next_o
);

    generate
        if (MODE == LFSR_GAL) begin : g_gal
            // Galois: shift right, fold the tap mask in when a one falls out of bit 0
            assign next_o = (state_i >> 1) ^ (state_i[0] ? poly_i : '0);
        end else begin : g_fib
            // Fibonacci: parity of the tapped bits enters at the LSB
            assign next_o = {state_i[WIDTH-2:0], ^(state_i & poly_i)};
        end
    endgenerate

endmodule

// File: rtl/lfsr_param.sv
// rtl/lfsr_param.sv - parameterised LFSR with seed load, wrap detect and optional period counter (LFSR_PERIOD_CNT_EN)
module lfsr_param
    import lfsr_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int STEPS = 1,
    parameter int MODE  = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [WIDTH-1:0]      seed,
    input  logic [WIDTH-1:0]      poly,
    input  logic                  load,
    input  logic                  en,
    output logic [WIDTH-1:0]      shift_seed,
    output logic                  valid,
    output logic                  wrap,
    output logic                  lockup,
    output logic [LFSR_CNT_W-1:0] period
);

    lfsr_state_e      state_q, state_d;
    logic [WIDTH-1:0] lfsr_q,  lfsr_d;
    logic [WIDTH-1:0] seed_q,  seed_d;
    logic [WIDTH-1:0] poly_q,  poly_d;
    logic             wrap_q,  wrap_d;

    // STEPS single-step stages chained back to back; only the last result is registered
    logic [STEPS:0][WIDTH-1:0] chain;
    logic [WIDTH-1:0]          step_res;

    assign chain[0] = lfsr_q;

    for (genvar i = 0; i < STEPS; i++) begin : g_chain
        lfsr_step #(
            .WIDTH (WIDTH),
            .MODE  (MODE)
        ) u_step (
            .state_i (chain[i]),
            .poly_i  (poly_q),
            .next_o  (chain[i+1])
        );
    end

    assign step_res = chain[STEPS];

    // Next state: load beats stepping; only RUN advances; a zero result locks up
    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        seed_d  = seed_q;
        poly_d  = poly_q;
        wrap_d  = 1'b0;
        if (load) begin
            seed_d  = seed;
            poly_d  = poly;
            lfsr_d  = seed;
            state_d = (seed != '0) ? ST_RUN : ST_LOCKED;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (en) begin
                        lfsr_d = step_res;
                        wrap_d = (step_res == seed_q);
                        if (step_res == '0) begin
                            state_d = ST_LOCKED;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // State and data registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            lfsr_q  <= '0;
            seed_q  <= '0;
            poly_q  <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            seed_q  <= seed_d;
            poly_q  <= poly_d;
            wrap_q  <= wrap_d;
        end
    end

    assign shift_seed = lfsr_q;
    assign valid      = (state_q == ST_RUN);
    assign lockup     = (state_q == ST_LOCKED);
    assign wrap       = wrap_q;

`ifdef LFSR_PERIOD_CNT_EN
    logic [LFSR_CNT_W-1:0] cnt_q,    cnt_d;
    logic [LFSR_CNT_W-1:0] period_q, period_d;
    logic [LFSR_CNT_W:0]   cnt_sum;

    // Saturating step counter; period latches the count on the first wrap
    // (a captured period is never zero, so zero doubles as "not yet captured")
    always_comb begin
        cnt_d    = cnt_q;
        period_d = period_q;
        cnt_sum  = {1'b0, cnt_q} + (LFSR_CNT_W+1)'(STEPS);
        if (load) begin
            cnt_d    = '0;
            period_d = '0;
        end else if ((state_q == ST_RUN) && en) begin
            cnt_d = cnt_sum[LFSR_CNT_W] ? LFSR_CNT_MAX : cnt_sum[LFSR_CNT_W-1:0];
            if (wrap_d && (period_q == '0)) begin
                period_d = cnt_d;
            end
        end
    end

    // Counter and captured period registers
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= '0;
            period_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            period_q <= period_d;
        end
    end

    assign period = period_q;
`else
    assign period = '0;
`endif

endmodule

// File: tb/tb_lfsr_param.sv
// tb/tb_lfsr_param.sv - self-checking bench for lfsr_param (Fibonacci 4-bit x1/x3, Galois 64-bit x2)
module tb_lfsr_param;

`ifdef LFSR_PERIOD_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        a_load, a_en;
    logic [3:0]  a_seed, a_poly;
    logic        g_load, g_en;
    logic [63:0] g_seed, g_poly;

    logic [3:0]  d1_ss, d3_ss;
    logic [63:0] g_ss;
    logic        d1_v, d1_w, d1_l, d3_v, d3_w, d3_l, g_v, g_w, g_l;
    logic [31:0] d1_p, d3_p, g_p;

    lfsr_param #(.WIDTH(4), .STEPS(1), .MODE(0)) u_d1 (
        .clk(clk), .reset(rst), .seed(a_seed), .poly(a_poly), .load(a_load), .en(a_en),
        .shift_seed(d1_ss), .valid(d1_v), .wrap(d1_w), .lockup(d1_l), .period(d1_p));

    lfsr_param #(.WIDTH(4), .STEPS(3), .MODE(0)) u_d3 (
        .clk(clk), .reset(rst), .seed(a_seed), .poly(a_poly), .load(a_load), .en(a_en),
        .shift_seed(d3_ss), .valid(d3_v), .wrap(d3_w), .lockup(d3_l), .period(d3_p));

    lfsr_param #(.WIDTH(64), .STEPS(2), .MODE(1)) u_g (
        .clk(clk), .reset(rst), .seed(g_seed), .poly(g_poly), .load(g_load), .en(g_en),
        .shift_seed(g_ss), .valid(g_v), .wrap(g_w), .lockup(g_l), .period(g_p));

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: mode 0 idle, 1 running, 2 locked
    typedef struct {
        int              mode;
        logic [63:0]     s;
        logic [63:0]     seed;
        logic [63:0]     poly;
        longint unsigned cnt;
        longint unsigned period;
        bit              cap;
        bit              wrap;
    } mdl_t;

    mdl_t m [3];
    int   mw [3] = '{4, 4, 64};
    int   ms [3] = '{1, 3, 2};
    int   mm [3] = '{0, 0, 1};

    function automatic logic [63:0] ref_step(logic [63:0] s, logic [63:0] poly, int w, int md);
        logic [63:0] mask;
        mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        if (md == 1) begin
            return ((s / 2) ^ ((s % 2 == 1) ? poly : 64'd0)) & mask;
        end
        return ((s * 2) + 64'($countones(s & poly) % 2)) & mask;
    endfunction

    task automatic mdl_update(input int k, input bit r, input bit ld, input bit e,
                              input logic [63:0] sd, input logic [63:0] pl);
        logic [63:0] s;
        if (r) begin
            m[k] = '{mode: 0, s: 64'd0, seed: 64'd0, poly: 64'd0, cnt: 0, period: 0, cap: 1'b0, wrap: 1'b0};
        end else if (ld) begin
            m[k].s      = sd;
            m[k].seed   = sd;
            m[k].poly   = pl;
            m[k].mode   = (sd != 64'd0) ? 1 : 2;
            m[k].cnt    = 0;
            m[k].period = 0;
            m[k].cap    = 1'b0;
            m[k].wrap   = 1'b0;
        end else if (m[k].mode == 1 && e) begin
            s = m[k].s;
            for (int i = 0; i < ms[k]; i++) s = ref_step(s, m[k].poly, mw[k], mm[k]);
            m[k].wrap = (s == m[k].seed);
            m[k].cnt  = m[k].cnt + longint'(ms[k]);
            if (m[k].cnt > 64'hFFFF_FFFF) m[k].cnt = 64'hFFFF_FFFF;
            if (m[k].wrap && !m[k].cap) begin
                m[k].period = m[k].cnt;
                m[k].cap    = 1'b1;
            end
            m[k].s = s;
            if (s == 64'd0) m[k].mode = 2;
        end else begin
            m[k].wrap = 1'b0;
        end
    endtask

    task automatic tick();
        mdl_update(0, rst, a_load, a_en, 64'(a_seed), 64'(a_poly));
        mdl_update(1, rst, a_load, a_en, 64'(a_seed), 64'(a_poly));
        mdl_update(2, rst, g_load, g_en, g_seed, g_poly);
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input int k);
        logic [63:0] ss;
        logic        v, w, l;
        logic [31:0] p;
        string       tag;
        case (k)
            0:       begin ss = 64'(d1_ss); v = d1_v; w = d1_w; l = d1_l; p = d1_p; tag = "rnd_d1"; end
            1:       begin ss = 64'(d3_ss); v = d3_v; w = d3_w; l = d3_l; p = d3_p; tag = "rnd_d3"; end
            default: begin ss = g_ss;       v = g_v;  w = g_w;  l = g_l;  p = g_p;  tag = "rnd_g";  end
        endcase
        chk({tag, "_ss"},     ss, m[k].s);
        chk({tag, "_valid"},  64'(v), 64'(m[k].mode == 1));
        chk({tag, "_wrap"},   64'(w), 64'(m[k].wrap));
        chk({tag, "_lockup"}, 64'(l), 64'(m[k].mode == 2));
        chk({tag, "_period"}, 64'(p), CNT_EN ? m[k].period : 64'd0);
    endtask

    typedef struct {
        bit         ld;
        bit         e;
        logic [3:0] sd;
        logic [3:0] pl;
        logic [3:0] ss;
        bit         v;
        bit         lk;
    } vec_t;

    vec_t       tbl [14];
    logic [3:0] seq [16];

    initial begin
        logic [31:0] p15;
        int          k3;

        seq = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA,
                4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h1};
        tbl[0]  = '{1'b1, 1'b0, 4'h0, 4'hC, 4'h0, 1'b0, 1'b1};
        tbl[1]  = '{1'b0, 1'b1, 4'h0, 4'hC, 4'h0, 1'b0, 1'b1};
        tbl[2]  = '{1'b0, 1'b1, 4'h0, 4'hC, 4'h0, 1'b0, 1'b1};
        tbl[3]  = '{1'b1, 1'b1, 4'h1, 4'hC, 4'h1, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 4'h1, 4'hC, 4'h2, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 4'h1, 4'hC, 4'h2, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 4'h1, 4'hC, 4'h4, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 4'h1, 4'hC, 4'h9, 1'b1, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 4'h5, 4'hC, 4'h5, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 4'h5, 4'hC, 4'hB, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 4'h5, 4'hC, 4'h7, 1'b1, 1'b0};
        tbl[11] = '{1'b1, 1'b0, 4'h8, 4'h0, 4'h8, 1'b1, 1'b0};
        tbl[12] = '{1'b0, 1'b1, 4'h8, 4'h0, 4'h0, 1'b0, 1'b1};
        tbl[13] = '{1'b0, 1'b1, 4'h8, 4'h0, 4'h0, 1'b0, 1'b1};
        p15 = CNT_EN ? 32'd15 : 32'd0;

        rst = 1'b1; a_load = 1'b0; a_en = 1'b0; a_seed = 4'h0; a_poly = 4'h0;
        g_load = 1'b0; g_en = 1'b0; g_seed = 64'd0; g_poly = 64'd0;
        tick();
        tick();
        chk("rst_d1_ss", 64'(d1_ss), 64'd0);
        chk("rst_d1_flags", 64'({d1_v, d1_w, d1_l}), 64'd0);
        chk("rst_d1_period", 64'(d1_p), 64'd0);
        chk("rst_g_ss", g_ss, 64'd0);
        chk("rst_g_flags", 64'({g_v, g_w, g_l}), 64'd0);

        rst = 1'b0; a_en = 1'b1; g_en = 1'b1;
        tick();
        tick();
        chk("idle_en_ss", 64'(d1_ss), 64'd0);
        chk("idle_en_valid", 64'(d1_v), 64'd0);
        chk("idle_en_g_ss", g_ss, 64'd0);

        for (int i = 0; i < 14; i++) begin
            a_load = tbl[i].ld; a_en = tbl[i].e; a_seed = tbl[i].sd; a_poly = tbl[i].pl;
            tick();
            chk($sformatf("tbl%0d_ss", i), 64'(d1_ss), 64'(tbl[i].ss));
            chk($sformatf("tbl%0d_valid", i), 64'(d1_v), 64'(tbl[i].v));
            chk($sformatf("tbl%0d_lockup", i), 64'(d1_l), 64'(tbl[i].lk));
            chk($sformatf("tbl%0d_wrap", i), 64'(d1_w), 64'd0);
        end

        // Full 15-state Fibonacci sequence; the x3 instance runs alongside
        a_load = 1'b1; a_en = 1'b0; a_seed = 4'h1; a_poly = 4'hC;
        tick();
        chk("seq_load_ss", 64'(d1_ss), 64'h1);
        chk("seq_load_d3_ss", 64'(d3_ss), 64'h1);
        a_load = 1'b0; a_en = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            k3 = (3 * k) % 15;
            chk($sformatf("seq1_%0d_ss", k), 64'(d1_ss), 64'(seq[k % 15]));
            chk($sformatf("seq1_%0d_wrap", k), 64'(d1_w), 64'(k == 15));
            chk($sformatf("seq1_%0d_period", k), 64'(d1_p), 64'((k >= 15) ? p15 : 32'd0));
            chk($sformatf("seq3_%0d_ss", k), 64'(d3_ss), 64'(seq[k3]));
            chk($sformatf("seq3_%0d_wrap", k), 64'(d3_w), 64'(k3 == 0));
            chk($sformatf("seq3_%0d_period", k), 64'(d3_p), 64'((k >= 5) ? p15 : 32'd0));
        end

        // Held state after a wrap must not re-pulse wrap
        a_en = 1'b0;
        tick();
        tick();
        chk("hold_d1_wrap", 64'(d1_w), 64'd0);

        // Reset mid-run abandons the sequence
        a_en = 1'b1; rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_ss", 64'(d1_ss), 64'd0);
        chk("midrst_flags", 64'({d1_v, d1_w, d1_l}), 64'd0);
        chk("midrst_period", 64'(d1_p), 64'd0);
        chk("midrst_d3_ss", 64'(d3_ss), 64'd0);
        tick();
        tick();
        chk("midrst_en_ss", 64'(d1_ss), 64'd0);
        chk("midrst_en_valid", 64'(d1_v), 64'd0);
        a_load = 1'b1; a_seed = 4'h1; a_poly = 4'hC;
        tick();
        a_load = 1'b0;
        chk("restart_ss", 64'(d1_ss), 64'h1);
        chk("restart_valid", 64'(d1_v), 64'd1);
        tick();
        chk("restart_step", 64'(d1_ss), 64'h2);

        // 64-bit Galois: load with en same cycle, then hand-computed steps
        g_load = 1'b1; g_en = 1'b1; g_seed = 64'h100; g_poly = 64'hD800_0000_0000_0000;
        tick();
        g_load = 1'b0;
        chk("g_load_ss", g_ss, 64'h100);
        chk("g_load_valid", 64'(g_v), 64'd1);
        tick();
        chk("g_step_ss", g_ss, 64'h40);
        g_load = 1'b1; g_seed = 64'h1;
        tick();
        g_load = 1'b0;
        tick();
        chk("g_tap_ss", g_ss, 64'h6C00_0000_0000_0000);

        // Randomised run against the reference model
        for (int c = 0; c < 3000; c++) begin
            rst    = ($urandom_range(0, 59) == 0);
            a_load = ($urandom_range(0, 9) == 0);
            a_en   = ($urandom_range(0, 3) != 0);
            a_seed = 4'($urandom_range(0, 15));
            a_poly = 4'($urandom_range(0, 15));
            g_load = ($urandom_range(0, 19) == 0);
            g_en   = ($urandom_range(0, 3) != 0);
            g_seed = ($urandom_range(0, 7) == 0) ? 64'd0 : {$urandom, $urandom};
            g_poly = {$urandom, $urandom};
            tick();
            for (int k = 0; k < 3; k++) check_model(k);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
